// File: rtl/MemoryArbiterTypes.sv
// MemoryArbiterTypes: shared state encoding and owner codes for the PSRAM arbiter
package MemoryArbiterTypes;
  typedef enum logic [7:0] {
    IDLE    = 8'd1,
    BUSY_WR = 8'd2,
    BUSY_RD = 8'd3
  } t_state;
  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_WR   = 2'd1;
  localparam logic [1:0] OWNER_RD   = 2'd2;
endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin PSRAM burst arbiter between camera writer and frame reader
module memory_arbiter
  import MemoryArbiterTypes::*;
#(
  parameter int CMD_INTERVAL = 14,
  parameter int ADDR_WIDTH   = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_calib,
  input  logic                  wr_rq,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_ack,
  input  logic                  rd_rq,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic                  psram_cmd,
  output logic                  psram_cmd_en,
  output logic [ADDR_WIDTH-1:0] psram_addr,
  output logic [1:0]            owner
);
  localparam int GW = (CMD_INTERVAL > 1) ? $clog2(CMD_INTERVAL) : 1;
  t_state                r_state;
  logic [1:0]            r_owner;
  logic                  r_wr_ack;
  logic                  r_rd_ack;
  logic                  r_cmd;
  logic                  r_cmd_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [GW-1:0]         r_gap;
  logic                  r_last_wr;
  logic                  w_can;
  logic                  w_gnt_wr;
  logic                  w_gnt_rd;
  logic                  w_gnt;
  logic                  w_release;
  // Grant decision: write wins a tie unless it was served last; owner releases when its rq drops
  always_comb begin
    w_can     = (r_state == IDLE) && init_calib && (r_gap == '0);
    w_gnt_wr  = w_can && wr_rq && (!rd_rq || !r_last_wr);
    w_gnt_rd  = w_can && rd_rq && !w_gnt_wr;
    w_gnt     = w_gnt_wr || w_gnt_rd;
    w_release = ((r_state == BUSY_WR) && !wr_rq) || ((r_state == BUSY_RD) && !rd_rq);
  end
  // Ownership state and one-cycle grant strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_owner  <= OWNER_NONE;
      r_wr_ack <= 1'b0;
      r_rd_ack <= 1'b0;
      r_cmd_en <= 1'b0;
    end else begin
      r_state  <= w_gnt_wr ? BUSY_WR : w_gnt_rd ? BUSY_RD : w_release ? IDLE : r_state;
      r_owner  <= w_gnt_wr ? OWNER_WR : w_gnt_rd ? OWNER_RD : w_release ? OWNER_NONE : r_owner;
      r_wr_ack <= w_gnt_wr;
      r_rd_ack <= w_gnt_rd;
      r_cmd_en <= w_gnt;
    end
  end
  // Command/address latch, round-robin memory and gap counter (loaded alongside the strobe so spacing is exactly CMD_INTERVAL)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd     <= 1'b0;
      r_addr    <= '0;
      r_last_wr <= 1'b0;
      r_gap     <= '0;
    end else if (w_gnt) begin
      r_cmd     <= w_gnt_wr;
      r_addr    <= w_gnt_wr ? wr_addr : rd_addr;
      r_last_wr <= w_gnt_wr;
      r_gap     <= GW'(CMD_INTERVAL - 1);
    end else if (r_gap != '0) begin
      r_gap <= r_gap - 1'b1;
    end
  end
  assign wr_ack       = r_wr_ack;
  assign rd_ack       = r_rd_ack;
  assign psram_cmd    = r_cmd;
  assign psram_cmd_en = r_cmd_en;
  assign psram_addr   = r_addr;
  assign owner        = r_owner;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed self-checking bench for memory_arbiter
module tb_memory_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_calib = 1'b0;
  logic        wr_rq = 1'b0;
  logic [20:0] wr_addr = '0;
  logic        wr_ack;
  logic        rd_rq = 1'b0;
  logic [20:0] rd_addr = '0;
  logic        rd_ack;
  logic        psram_cmd;
  logic        psram_cmd_en;
  logic [20:0] psram_addr;
  logic [1:0]  owner;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  memory_arbiter dut (
    .clk(clk), .reset(reset), .init_calib(init_calib),
    .wr_rq(wr_rq), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .rd_rq(rd_rq), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .psram_cmd(psram_cmd), .psram_cmd_en(psram_cmd_en),
    .psram_addr(psram_addr), .owner(owner)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut();
    reset = 1'b1;
    wr_rq = 1'b0;
    rd_rq = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic wait_cmd(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      tick();
      if (psram_cmd_en) at = cyc;
    end
    if (at < 0) chk("cmd_timeout", 0, 1);
  endtask
  initial begin
    int t;
    int last;
    bit served_wr;
    bit any_ack;
    init_calib = 1'b1;
    reset_dut();
    chk("rst_owner", 32'(owner), 0);
    chk("rst_acks", {wr_ack, rd_ack, psram_cmd_en}, 0);
    chk("rst_cmd", 32'(psram_cmd), 0);
    chk("rst_addr", 32'(psram_addr), 0);
    repeat (8) tick();
    chk("idle_owner", 32'(owner), 0);
    rd_addr = 21'h01234;
    rd_rq = 1'b1;
    tick();
    chk("rd_only_ack", {wr_ack, rd_ack, psram_cmd_en}, 3'b011);
    chk("rd_only_cmd", 32'(psram_cmd), 0);
    chk("rd_only_addr", 32'(psram_addr), 32'h01234);
    chk("rd_only_owner", 32'(owner), 2);
    tick();
    chk("rd_pulse_one", {wr_ack, rd_ack, psram_cmd_en}, 0);
    chk("rd_hold_owner", 32'(owner), 2);
    rd_rq = 1'b0;
    tick();
    chk("rd_release", 32'(owner), 0);
    reset_dut();
    wr_addr = 21'h1ABCD;
    rd_addr = 21'h05555;
    wr_rq = 1'b1;
    rd_rq = 1'b1;
    wait_cmd(5, t);
    chk("tie0_wr", {wr_ack, rd_ack}, 2'b10);
    chk("tie0_cmd", 32'(psram_cmd), 1);
    chk("tie0_addr", 32'(psram_addr), 32'h1ABCD);
    last = t;
    served_wr = 1'b1;
    for (int k = 1; k < 4; k++) begin
      repeat (3) tick();
      if (served_wr) wr_rq = 1'b0; else rd_rq = 1'b0;
      tick();
      chk("rr_release", 32'(owner), 0);
      wr_rq = 1'b1;
      rd_rq = 1'b1;
      wait_cmd(30, t);
      chk("rr_spacing", t - last, 14);
      chk("rr_acks", {wr_ack, rd_ack}, served_wr ? 2'b01 : 2'b10);
      chk("rr_owner", 32'(owner), served_wr ? 2 : 1);
      chk("rr_addr", 32'(psram_addr), served_wr ? 32'h05555 : 32'h1ABCD);
      last = t;
      served_wr = !served_wr;
    end
    init_calib = 1'b0;
    reset_dut();
    wr_rq = 1'b1;
    rd_rq = 1'b1;
    any_ack = 1'b0;
    repeat (50) begin
      tick();
      if (wr_ack || rd_ack || psram_cmd_en) any_ack = 1'b1;
    end
    chk("nocal_no_ack", 32'(any_ack), 0);
    init_calib = 1'b1;
    tick();
    chk("cal_wr_ack", {wr_ack, rd_ack, psram_cmd_en}, 3'b101);
    last = cyc;
    tick();
    wr_rq = 1'b0;
    tick();
    wait_cmd(30, t);
    chk("early_rel_spacing", t - last, 14);
    chk("early_rel_rd", {wr_ack, rd_ack}, 2'b01);
    repeat (2) tick();
    chk("busy_rd_owner", 32'(owner), 2);
    reset = 1'b1;
    tick();
    chk("midrst_owner", 32'(owner), 0);
    chk("midrst_strobes", {wr_ack, rd_ack, psram_cmd_en}, 0);
    chk("midrst_addr", 32'(psram_addr), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_rd_ack", {wr_ack, rd_ack, psram_cmd_en}, 3'b011);
    chk("post_rst_owner", 32'(owner), 2);
    reset_dut();
    wr_addr = 21'h00777;
    wr_rq = 1'b1;
    tick();
    chk("pulse_wr_ack", 32'(wr_ack), 1);
    wr_rq = 1'b0;
    tick();
    chk("immediate_release", 32'(owner), 0);
    chk("cmd_holds", 32'(psram_cmd), 1);
    chk("addr_holds", 32'(psram_addr), 32'h00777);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter CMD_INTERVAL, default 14, minimum clk cycles between consecutive psram_cmd_en pulses (controller tCMD for one burst).
REQ-002 Parameter ADDR_WIDTH, default 21, PSRAM word address width.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 init_calib  input  1  PSRAM controller calibrated; no grants while low.
REQ-007 wr_rq  input  1  write requester (camera uploader) request, level, held until burst complete.
REQ-008 wr_addr  input  ADDR_WIDTH  write burst address, stable while wr_rq high.
REQ-009 wr_ack  output  1  one-cycle grant pulse to write requester.
REQ-010 rd_rq  input  1  read requester (frame downloader) request, level, held until burst complete.
REQ-011 rd_addr  input  ADDR_WIDTH  read burst address, stable while rd_rq high.
REQ-012 rd_ack  output  1  one-cycle grant pulse to read requester.
REQ-013 psram_cmd  output  1  command to controller: 1 = write, 0 = read; holds last value between commands.
REQ-014 psram_cmd_en  output  1  one-cycle command strobe to controller.
REQ-015 psram_addr  output  ADDR_WIDTH  registered address of the granted requester, held until next grant.
REQ-016 owner  output  2  current owner: 0 none, 1 write, 2 read.

Function
REQ-017 States: IDLE, BUSY_WR, BUSY_RD.
REQ-018 In IDLE, a grant is issued when init_calib is high, gap counter is 0 and at least one rq is high.
REQ-019 The grant is registered: rq sampled high in cycle N yields ack, psram_cmd_en, psram_cmd and psram_addr all valid in cycle N+1.
REQ-020 Only one requester pending: it is granted.
REQ-021 Both pending: round-robin; the requester not served last is granted; after reset, write wins the first tie.
REQ-022 On a write grant: wr_ack=1, psram_cmd=1, psram_addr=wr_addr, owner=1, next state BUSY_WR; read grant symmetric with psram_cmd=0, owner=2, BUSY_RD.
REQ-023 wr_ack, rd_ack and psram_cmd_en are high for exactly one cycle per grant and never high simultaneously for both acks.
REQ-024 In BUSY_x, the arbiter waits for the owner's rq to go low, then returns to IDLE with owner=0 in the next cycle; the other rq is ignored meanwhile.
REQ-025 Earliest re-grant after a release is the cycle after IDLE is entered, subject to REQ-026.
REQ-026 Gap counter: loaded with CMD_INTERVAL-1 on every psram_cmd_en, decrements by 1 per cycle to 0, saturates at 0; cmd_en spacing is never below CMD_INTERVAL cycles.
REQ-027 init_calib falling during BUSY_x does not abort ownership; the arbiter releases normally, then blocks grants until init_calib is high again.
REQ-028 An rq rising in the same cycle the owner releases is eligible from IDLE on the following cycle.
REQ-029 An owner's rq that is already low in the first BUSY_x cycle releases immediately, per REQ-024.

Reset
REQ-030 On reset: state IDLE, owner 0, wr_ack 0, rd_ack 0, psram_cmd_en 0, psram_cmd 0, psram_addr 0, gap counter 0, round-robin pointer set so that write wins the next tie.
REQ-031 Reset asserted mid-burst drops ownership in the next cycle; no ack or cmd_en is issued in the reset cycle.

Structure
REQ-032 Package MemoryArbiterTypes holds the t_state enum (IDLE=8'd1, BUSY_WR=8'd2, BUSY_RD=8'd3) and the owner encoding constants.
REQ-033 No sub-module: the gap counter and round-robin pointer are inline registers.

Verification
REQ-034 Only rd_rq high at cycle 10, init_calib=1, rd_addr=0x01234 -> cycle 11: rd_ack=1, psram_cmd_en=1, psram_cmd=0, psram_addr=0x01234, owner=2.
REQ-035 wr_rq and rd_rq both high from reset release, each dropping 3 cycles after its ack -> grants alternate W,R,W,R; psram_cmd_en spacing is at least 14 cycles.
REQ-036 init_calib=0 with both rq high for 50 cycles -> no ack; init_calib rises at cycle 50 -> wr_ack at cycle 51.
REQ-037 Owner releases 2 cycles after its grant, other rq pending -> next grant exactly CMD_INTERVAL cycles after the previous cmd_en.
REQ-038 Reset pulsed during BUSY_RD with rd_rq still high -> next cycle owner=0 and all strobes 0; rd_ack reissued once reset deasserts.
